// File: rtl/kt_cmd_pkg.sv
// Shared types and constants for the KnightsTour command sequencer.
// Imported by the command FIFO and the sequencer top.
package kt_cmd_pkg;

    localparam logic [7:0] ACK_BYTE = 8'hA5;

    localparam logic [3:0] CMD_CAL  = 4'h2;
    localparam logic [3:0] CMD_MOVE = 4'h4;
    localparam logic [3:0] CMD_TOUR = 4'h6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_SENT,
        S_WAIT_RESP,
        S_ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_NACK    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_code_t;

    function automatic logic is_known_op(input logic [15:0] c);
        return (c[15:12] == CMD_CAL) ||
               (c[15:12] == CMD_MOVE) ||
               (c[15:12] == CMD_TOUR);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Flop-based command queue with push/pop/flush.
// A push while full is dropped even if a pop happens in the same cycle.
module cmd_fifo
    import kt_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_cnt == FULL_CNT);
    assign empty     = (r_cnt == '0);
    assign count     = r_cnt;
    assign dout      = r_mem[r_rd];
    assign w_push_ok = push && !full && !flush;
    assign w_pop_ok  = pop && !empty && !flush;

    // Pointer/count bookkeeping; flush wins over everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push_ok) begin
            r_mem[r_wr] <= din;
        end
    end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Issues queued 16-bit commands to RemoteComm one at a time,
// waiting for a positive ack; flags NACK, timeout and overflow.
module tour_cmd_sequencer
    import kt_cmd_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] push_cmd,
    input  logic        clr_err,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic [15:0] cmd,
    output logic        send_cmd,
    output logic        full,
    output logic        busy,
    output logic        done,
    output logic [7:0]  ack_cnt,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        ovf
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYC - 1);

    seq_state_t  r_state;
    logic [15:0] r_cmd;
    logic        r_send;
    logic        r_done;
    logic [7:0]  r_ack;
    logic        r_err;
    err_code_t   r_code;
    logic        r_ovf;
    logic [23:0] r_timer;

    logic [15:0]   w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_ack;
    logic          w_nack;
    logic          w_tmo;
    logic          w_flush;
    logic          w_last;

    assign w_ack   = (r_state == S_WAIT_RESP) && resp_rdy && (resp == ACK_BYTE);
    assign w_nack  = (r_state == S_WAIT_RESP) && resp_rdy && (resp != ACK_BYTE);
    assign w_tmo   = (r_timer == TMO_LAST) && !resp_rdy;
    assign w_flush = (r_state == S_ERR) && clr_err;
    assign w_last  = (w_count == CW'(1));

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_cmd),
        .pop   (w_ack),
        .flush (w_flush),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Sequencer FSM with its timer, ack counter and error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cmd   <= '0;
            r_send  <= 1'b0;
            r_done  <= 1'b0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
            r_timer <= '0;
        end else begin
            r_send <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) r_state <= S_SEND;
                end
                S_SEND: begin
                    r_cmd   <= w_head;
                    r_send  <= 1'b1;
                    r_timer <= '0;
                    r_state <= S_WAIT_SENT;
                end
                S_WAIT_SENT: begin
                    r_timer <= r_timer + 24'd1;
                    if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_code  <= ERR_TIMEOUT;
                        r_state <= S_ERR;
                    end else if (cmd_sent) begin
                        r_state <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    r_timer <= r_timer + 24'd1;
                    if (w_ack) begin
                        r_ack   <= r_ack + 8'd1;
                        r_done  <= w_last && !push;
                        r_state <= S_IDLE;
                    end else if (w_nack) begin
                        r_err   <= 1'b1;
                        r_code  <= ERR_NACK;
                        r_state <= S_ERR;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_code  <= ERR_TIMEOUT;
                        r_state <= S_ERR;
                    end
                end
                S_ERR: begin
                    if (clr_err) begin
                        r_err   <= 1'b0;
                        r_code  <= ERR_NONE;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky overflow: set on a dropped push, cleared by clr_err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (clr_err) begin
            r_ovf <= 1'b0;
        end else if (push && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign cmd      = r_cmd;
    assign send_cmd = r_send;
    assign full     = w_full;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign done     = r_done;
    assign ack_cnt  = r_ack;
    assign err      = r_err;
    assign err_code = r_code;
    assign ovf      = r_ovf;

endmodule
